// File: rtl/display_ctrl_pkg.sv
// Shared encodings for the alarm-clock front-panel sequencer.
// The state values double as the debug/LED code.
package display_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_RUN        = 3'd0,
      ST_VIEW_ALARM = 3'd1,
      ST_SET_T_HR   = 3'd2,
      ST_SET_T_MIN  = 3'd3,
      ST_SET_A_HR   = 3'd4,
      ST_SET_A_MIN  = 3'd5
   } state_t;

   localparam logic DISPLAY_TIME  = 1'b0;
   localparam logic DISPLAY_ALARM = 1'b1;

   function automatic logic is_set_state(input state_t st);
      return st inside {ST_SET_T_HR, ST_SET_T_MIN, ST_SET_A_HR, ST_SET_A_MIN};
   endfunction

   function automatic logic is_alarm_side(input state_t st);
      return st inside {ST_VIEW_ALARM, ST_SET_A_HR, ST_SET_A_MIN};
   endfunction

   function automatic logic is_hr_field(input state_t st);
      return st inside {ST_SET_T_HR, ST_SET_A_HR};
   endfunction

   function automatic logic is_min_field(input state_t st);
      return st inside {ST_SET_T_MIN, ST_SET_A_MIN};
   endfunction

endpackage

// File: rtl/inactivity_timer.sv
// Saturating tick counter with synchronous clear. The terminal flag marks the
// tick that brings the count to TIMEOUT_TICKS, so the caller can act on that edge.
module inactivity_timer #(
   parameter int TIMEOUT_TICKS = 20,
   parameter int TIMER_W       = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic tick,
   output logic terminal
);

   localparam logic [TIMER_W-1:0] LAST_C = TIMER_W'(TIMEOUT_TICKS - 1);
   localparam logic [TIMER_W-1:0] MAX_C  = TIMER_W'(TIMEOUT_TICKS);

   logic [TIMER_W-1:0] count_r;

   // count register: clear wins over tick, hold at saturation
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= {TIMER_W{1'b0}};
      end else if (clear) begin
         count_r <= {TIMER_W{1'b0}};
      end else if (tick && (count_r != MAX_C)) begin
         count_r <= count_r + TIMER_W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign terminal = tick && (count_r >= LAST_C);

endmodule

// File: rtl/display_mode_controller.sv
// Front-panel mode sequencer: decodes button pulses into display/set modes,
// emits increment strobes and blink blanking, and times out back to RUN.
module display_mode_controller
   import display_ctrl_pkg::*;
#(
   parameter int TIMEOUT_TICKS = 20,
   parameter int TIMER_W       = 5
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic       i_Tick,
   input  logic       i_Mode_Btn,
   input  logic       i_Inc_Btn,
   input  logic       i_Alarm_View_Btn,
   output logic       o_Display_Sel,
   output logic       o_Time_Hr_Inc,
   output logic       o_Time_Min_Inc,
   output logic       o_Alarm_Hr_Inc,
   output logic       o_Alarm_Min_Inc,
   output logic       o_Sec_Clr,
   output logic       o_Time_Run,
   output logic       o_Hr_Blank,
   output logic       o_Min_Blank,
   output logic [2:0] o_State
);

   state_t state_r;
   state_t state_nxt_s;
   logic   phase_r;

   logic   inc_take_s;
   logic   av_take_s;
   logic   btn_any_s;
   logic   terminal_s;
   logic   timeout_s;
   logic   timer_clear_s;

   logic   sel_nxt_s;
   logic   run_nxt_s;
   logic   th_inc_nxt_s;
   logic   tm_inc_nxt_s;
   logic   ah_inc_nxt_s;
   logic   am_inc_nxt_s;
   logic   sec_clr_nxt_s;
   logic   phase_nxt_s;
   logic   hr_blank_nxt_s;
   logic   min_blank_nxt_s;

   // Mode > Inc > Alarm_View: a higher-priority pulse swallows the others
   assign inc_take_s    = i_Inc_Btn && !i_Mode_Btn;
   assign av_take_s     = i_Alarm_View_Btn && !i_Mode_Btn && !i_Inc_Btn;
   assign btn_any_s     = i_Mode_Btn || i_Inc_Btn || i_Alarm_View_Btn;
   assign timeout_s     = terminal_s && !btn_any_s && (state_r != ST_RUN);
   assign timer_clear_s = btn_any_s || (state_nxt_s != state_r) || (state_r == ST_RUN);

   inactivity_timer #(
      .TIMEOUT_TICKS (TIMEOUT_TICKS),
      .TIMER_W       (TIMER_W)
   ) u_timer (
      .clk      (i_Clk),
      .reset    (i_Reset),
      .clear    (timer_clear_s),
      .tick     (i_Tick),
      .terminal (terminal_s)
   );

   // next-state decode
   always_comb begin
      state_nxt_s = state_r;
      if (i_Mode_Btn) begin
         case (state_r)
            ST_RUN:        state_nxt_s = ST_SET_T_HR;
            ST_SET_T_HR:   state_nxt_s = ST_SET_T_MIN;
            ST_SET_T_MIN:  state_nxt_s = ST_RUN;
            ST_VIEW_ALARM: state_nxt_s = ST_SET_A_HR;
            ST_SET_A_HR:   state_nxt_s = ST_SET_A_MIN;
            ST_SET_A_MIN:  state_nxt_s = ST_VIEW_ALARM;
            default:       state_nxt_s = ST_RUN;
         endcase
      end else if (av_take_s) begin
         case (state_r)
            ST_RUN:        state_nxt_s = ST_VIEW_ALARM;
            ST_VIEW_ALARM: state_nxt_s = ST_RUN;
            default:       state_nxt_s = state_r;
         endcase
      end else if (timeout_s) begin
         state_nxt_s = ST_RUN;
      end else begin
         state_nxt_s = state_r;
      end
   end

   // next values of every registered output, derived from the next state
   always_comb begin
      th_inc_nxt_s  = inc_take_s && (state_r == ST_SET_T_HR);
      tm_inc_nxt_s  = inc_take_s && (state_r == ST_SET_T_MIN);
      ah_inc_nxt_s  = inc_take_s && (state_r == ST_SET_A_HR);
      am_inc_nxt_s  = inc_take_s && (state_r == ST_SET_A_MIN);
      sec_clr_nxt_s = i_Mode_Btn && (state_r == ST_SET_T_MIN);
      sel_nxt_s     = is_alarm_side(state_nxt_s) ? DISPLAY_ALARM : DISPLAY_TIME;
      run_nxt_s     = !(state_nxt_s inside {ST_SET_T_HR, ST_SET_T_MIN});
      if (!is_set_state(state_nxt_s)) begin
         phase_nxt_s = 1'b1;
      end else if ((state_nxt_s != state_r) || (inc_take_s && is_set_state(state_r))) begin
         phase_nxt_s = 1'b1;
      end else if (i_Tick) begin
         phase_nxt_s = !phase_r;
      end else begin
         phase_nxt_s = phase_r;
      end
      hr_blank_nxt_s  = is_hr_field(state_nxt_s) && !phase_nxt_s;
      min_blank_nxt_s = is_min_field(state_nxt_s) && !phase_nxt_s;
   end

   // state, blink phase and output registers
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state_r         <= ST_RUN;
         phase_r         <= 1'b1;
         o_Display_Sel   <= DISPLAY_TIME;
         o_Time_Hr_Inc   <= 1'b0;
         o_Time_Min_Inc  <= 1'b0;
         o_Alarm_Hr_Inc  <= 1'b0;
         o_Alarm_Min_Inc <= 1'b0;
         o_Sec_Clr       <= 1'b0;
         o_Time_Run      <= 1'b1;
         o_Hr_Blank      <= 1'b0;
         o_Min_Blank     <= 1'b0;
      end else begin
         state_r         <= state_nxt_s;
         phase_r         <= phase_nxt_s;
         o_Display_Sel   <= sel_nxt_s;
         o_Time_Hr_Inc   <= th_inc_nxt_s;
         o_Time_Min_Inc  <= tm_inc_nxt_s;
         o_Alarm_Hr_Inc  <= ah_inc_nxt_s;
         o_Alarm_Min_Inc <= am_inc_nxt_s;
         o_Sec_Clr       <= sec_clr_nxt_s;
         o_Time_Run      <= run_nxt_s;
         o_Hr_Blank      <= hr_blank_nxt_s;
         o_Min_Blank     <= min_blank_nxt_s;
      end
   end

   assign o_State = state_r;

endmodule

// File: tb/tb_display_mode_controller.sv
// Bench for display_mode_controller: directed scenarios plus random pulses,
// every cycle compared against a table-driven behavioural model.
module tb_display_mode_controller;

   localparam int TIMEOUT = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b0, tick = 1'b0, mode_btn = 1'b0, inc_btn = 1'b0, av_btn = 1'b0;
   logic       display_sel, th_inc, tm_inc, ah_inc, am_inc, sec_clr, time_run;
   logic       hr_blank, min_blank;
   logic [2:0] state;

   int checks = 0;
   int failures = 0;

   // model: 0 RUN, 1 VIEW_ALARM, 2 SET_T_HR, 3 SET_T_MIN, 4 SET_A_HR, 5 SET_A_MIN
   int mode_next [6] = '{2, 4, 3, 0, 5, 1};
   int m_state = 0, m_timer = 0;
   bit m_phase = 1'b1;
   bit e_sel, e_th, e_tm, e_ah, e_am, e_sec, e_run, e_hrb, e_minb;

   display_mode_controller dut (
      .i_Clk            (clk),
      .i_Reset          (rst),
      .i_Tick           (tick),
      .i_Mode_Btn       (mode_btn),
      .i_Inc_Btn        (inc_btn),
      .i_Alarm_View_Btn (av_btn),
      .o_Display_Sel    (display_sel),
      .o_Time_Hr_Inc    (th_inc),
      .o_Time_Min_Inc   (tm_inc),
      .o_Alarm_Hr_Inc   (ah_inc),
      .o_Alarm_Min_Inc  (am_inc),
      .o_Sec_Clr        (sec_clr),
      .o_Time_Run       (time_run),
      .o_Hr_Blank       (hr_blank),
      .o_Min_Blank      (min_blank),
      .o_State          (state)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit t, input bit m, input bit n, input bit a);
      int  prev;
      bit  in_set, any, strobe;
      {e_th, e_tm, e_ah, e_am, e_sec} = 5'b0;
      if (r) begin
         m_state = 0;
         m_timer = 0;
         m_phase = 1'b1;
      end else begin
         prev   = m_state;
         in_set = (m_state >= 2);
         any    = m || n || a;
         strobe = 1'b0;
         if (m) begin
            e_sec   = (m_state == 3);
            m_state = mode_next[m_state];
         end else if (n) begin
            if (in_set) begin
               strobe = 1'b1;
               e_th = (m_state == 2);
               e_tm = (m_state == 3);
               e_ah = (m_state == 4);
               e_am = (m_state == 5);
            end
         end else if (a) begin
            if (m_state == 0) m_state = 1;
            else if (m_state == 1) m_state = 0;
         end else if (m_state != 0 && t && (m_timer + 1 >= TIMEOUT)) begin
            m_state = 0;
         end
         if (any || m_state != prev || m_state == 0) m_timer = 0;
         else if (t) m_timer = (m_timer + 1 > TIMEOUT) ? TIMEOUT : m_timer + 1;
         if (m_state < 2 || m_state != prev || strobe) m_phase = 1'b1;
         else if (t) m_phase = ~m_phase;
      end
      e_sel  = (m_state == 1 || m_state == 4 || m_state == 5);
      e_run  = !(m_state == 2 || m_state == 3);
      e_hrb  = (m_state == 2 || m_state == 4) && !m_phase;
      e_minb = (m_state == 3 || m_state == 5) && !m_phase;
   endtask

   task automatic compare_all();
      check_eq("state", {5'b0, state}, 8'(m_state));
      check_eq("display_sel", {7'b0, display_sel}, {7'b0, e_sel});
      check_eq("time_hr_inc", {7'b0, th_inc}, {7'b0, e_th});
      check_eq("time_min_inc", {7'b0, tm_inc}, {7'b0, e_tm});
      check_eq("alarm_hr_inc", {7'b0, ah_inc}, {7'b0, e_ah});
      check_eq("alarm_min_inc", {7'b0, am_inc}, {7'b0, e_am});
      check_eq("sec_clr", {7'b0, sec_clr}, {7'b0, e_sec});
      check_eq("time_run", {7'b0, time_run}, {7'b0, e_run});
      check_eq("hr_blank", {7'b0, hr_blank}, {7'b0, e_hrb});
      check_eq("min_blank", {7'b0, min_blank}, {7'b0, e_minb});
   endtask

   // drive at negedge, let one posedge pass, compare at the next negedge
   task automatic cycle(input bit r, input bit t, input bit m, input bit n, input bit a);
      rst = r; tick = t; mode_btn = m; inc_btn = n; av_btn = a;
      model_step(r, t, m, n, a);
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle(input int cnt);
      for (int i = 0; i < cnt; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic ticks(input int cnt);
      for (int i = 0; i < cnt; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      int strobes;
      @(negedge clk);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("reset_state", {5'b0, state}, 8'd0);
      check_eq("reset_run", {7'b0, time_run}, 8'd1);

      // RUN -> SET_T_HR, three hour increments
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check_eq("set_t_hr_state", {5'b0, state}, 8'd2);
      check_eq("set_t_hr_run", {7'b0, time_run}, 8'd0);
      check_eq("set_t_hr_sel", {7'b0, display_sel}, 8'd0);
      strobes = 0;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         strobes += int'(th_inc);
         idle(1);
         strobes += int'(th_inc);
      end
      check_eq("hr_strobe_count", 8'(strobes), 8'd3);

      // SET_T_MIN -> RUN with a single seconds clear
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check_eq("exit_state", {5'b0, state}, 8'd0);
      check_eq("exit_sec_clr", {7'b0, sec_clr}, 8'd1);
      idle(1);
      check_eq("sec_clr_one_cycle", {7'b0, sec_clr}, 8'd0);

      // alarm path
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check_eq("alarm_set_sel", {7'b0, display_sel}, 8'd1);
      check_eq("alarm_set_state", {5'b0, state}, 8'd4);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_eq("alarm_hr_strobe", {7'b0, ah_inc}, 8'd1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check_eq("alarm_min_state", {5'b0, state}, 8'd5);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check_eq("back_to_view", {5'b0, state}, 8'd1);

      // timeout from SET_A_MIN
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      ticks(TIMEOUT - 1);
      check_eq("pre_timeout_state", {5'b0, state}, 8'd5);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("timeout_state", {5'b0, state}, 8'd0);
      check_eq("timeout_sel", {7'b0, display_sel}, 8'd0);
      check_eq("timeout_no_sec_clr", {7'b0, sec_clr}, 8'd0);

      // Inc on the terminal tick wins and restarts the timer
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      ticks(TIMEOUT - 1);
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      check_eq("terminal_inc_state", {5'b0, state}, 8'd5);
      check_eq("terminal_inc_strobe", {7'b0, am_inc}, 8'd1);
      ticks(TIMEOUT - 1);
      check_eq("timer_restarted", {5'b0, state}, 8'd5);
      ticks(1);
      check_eq("second_timeout", {5'b0, state}, 8'd0);

      // blink in SET_T_MIN
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check_eq("blink_entry", {7'b0, min_blank}, 8'd0);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         check_eq("blink_min", {7'b0, min_blank}, (i % 2 == 0) ? 8'd1 : 8'd0);
         check_eq("blink_hr_quiet", {7'b0, hr_blank}, 8'd0);
      end
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("blink_hidden", {7'b0, min_blank}, 8'd1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_eq("inc_forces_visible", {7'b0, min_blank}, 8'd0);

      // Mode beats Inc in the same cycle
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      check_eq("prio_state", {5'b0, state}, 8'd3);
      check_eq("prio_no_hr_inc", {7'b0, th_inc}, 8'd0);

      // reset mid SET_A_HR
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check_eq("pre_reset_state", {5'b0, state}, 8'd4);
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      check_eq("mid_reset_state", {5'b0, state}, 8'd0);
      check_eq("mid_reset_sel", {7'b0, display_sel}, 8'd0);
      check_eq("mid_reset_no_strobe", {7'b0, ah_inc}, 8'd0);

      // random: busy stretch then quiet stretch so timeouts occur
      for (int i = 0; i < 1500; i++)
         cycle($urandom_range(499) == 0, $urandom_range(3) == 0, $urandom_range(5) == 0,
               $urandom_range(5) == 0, $urandom_range(5) == 0);
      for (int i = 0; i < 3000; i++)
         cycle($urandom_range(999) == 0, $urandom_range(1) == 0, $urandom_range(59) == 0,
               $urandom_range(59) == 0, $urandom_range(59) == 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/display_mode_controller.md
Name: display_mode_controller

Overview:
Front-panel sequencer for the alarm clock. Decodes debounced button pulses into display and set modes, and drives the time/alarm display select into the seven-segment PM mux. Issues single-cycle increment strobes to the time and alarm counters, and produces the digit-blank signals used while setting. An inactivity timeout returns the clock to the normal time display.

Parameters:
TIMEOUT_TICKS, 20, number of i_Tick pulses without button activity before a forced return to RUN (10 s at 2 Hz)
TIMER_W, 5, width of the inactivity counter; must hold TIMEOUT_TICKS

Ports:
i_Clk  in  1  system clock
i_Reset  in  1  synchronous, active-high reset
i_Tick  in  1  single-cycle enable at 2 Hz; drives blink and timeout
i_Mode_Btn  in  1  debounced single-cycle pulse: advance mode
i_Inc_Btn  in  1  debounced single-cycle pulse: increment the field being set
i_Alarm_View_Btn  in  1  debounced single-cycle pulse: toggle alarm view
o_Display_Sel  out  1  0 = time, 1 = alarm time; feeds the display mux select
o_Time_Hr_Inc  out  1  1-cycle strobe to the time hour counter
o_Time_Min_Inc  out  1  1-cycle strobe to the time minute counter
o_Alarm_Hr_Inc  out  1  1-cycle strobe to the alarm hour counter
o_Alarm_Min_Inc  out  1  1-cycle strobe to the alarm minute counter
o_Sec_Clr  out  1  1-cycle strobe to clear seconds on leaving SET_T_MIN
o_Time_Run  out  1  1 = timekeeping counts; 0 while setting time
o_Hr_Blank  out  1  blank hour digits (blink)
o_Min_Blank  out  1  blank minute digits (blink)
o_State  out  3  current state encoding, for debug and LEDs

Behaviour:
- All outputs are registered. Every output responds 1 cycle after the causing input pulse.
- Reset values: state RUN, o_Display_Sel=0, all strobes=0, o_Time_Run=1, blanks=0, timer=0, blink phase=1 (visible).
- States: RUN, VIEW_ALARM, SET_T_HR, SET_T_MIN, SET_A_HR, SET_A_MIN.
- Transitions on i_Mode_Btn:
  - RUN->SET_T_HR->SET_T_MIN->RUN. o_Sec_Clr pulses on the SET_T_MIN->RUN exit only.
  - VIEW_ALARM->SET_A_HR->SET_A_MIN->VIEW_ALARM.
- Transitions on i_Alarm_View_Btn:
  - RUN<->VIEW_ALARM.
  - Ignored in all SET states.
- i_Inc_Btn in a SET state: one strobe on the matching *_Inc output. In RUN or VIEW_ALARM it is ignored.
- Same-cycle priority: Mode > Inc > Alarm_View. Lower-priority pulses in that cycle are dropped.
- o_Display_Sel = 1 in VIEW_ALARM, SET_A_HR and SET_A_MIN; 0 otherwise.
- o_Time_Run = 0 in SET_T_HR and SET_T_MIN; 1 otherwise.
- Inactivity timer:
  - Clears on any button pulse and on every state change.
  - Otherwise increments on i_Tick and saturates at TIMEOUT_TICKS.
  - Reaching TIMEOUT_TICKS in any state other than RUN forces RUN next cycle. No o_Sec_Clr is issued on a timeout exit.
  - A button pulse in the same cycle as the terminal tick wins: it is processed normally and the timer clears.
  - The timer is inactive in RUN (held at 0).
- Blink:
  - Phase toggles on i_Tick in SET states.
  - Phase forces to 1 (visible) on SET-state entry and on each Inc strobe.
  - o_Hr_Blank = ~phase in SET_*_HR; o_Min_Blank = ~phase in SET_*_MIN. Both are 0 elsewhere.
- i_Reset mid-operation overrides everything: reset values on the next edge, and no strobes are emitted.
- Strobes never last more than 1 cycle and never coincide with each other.

Decomposition:
- Shared package display_ctrl_pkg:
  - state encodings ST_RUN=0, ST_VIEW_ALARM=1, ST_SET_T_HR=2, ST_SET_T_MIN=3, ST_SET_A_HR=4, ST_SET_A_MIN=5
  - display selects DISPLAY_TIME=0, DISPLAY_ALARM=1, matching the PM mux encoding
- One sub-module, inactivity_timer: clear, tick, saturating count, terminal flag; parameterised on TIMEOUT_TICKS and TIMER_W.

Test Plan:
- Reset then Mode -> 1 cycle later o_State=SET_T_HR, o_Time_Run=0, o_Display_Sel=0. Three Inc pulses -> exactly 3 one-cycle o_Time_Hr_Inc strobes.
- From SET_T_HR: Mode, then Mode -> o_State=RUN, o_Time_Run=1, o_Sec_Clr high for exactly 1 cycle.
- Alarm_View, then Mode, then Inc -> o_Display_Sel=1, o_State=SET_A_HR, one o_Alarm_Hr_Inc strobe. Next Mode gives SET_A_MIN; next Mode returns to VIEW_ALARM.
- In SET_A_MIN, 20 ticks with no buttons -> RUN after the 20th tick, o_Display_Sel=0, no o_Sec_Clr. Repeat with an Inc pulse on the 20th tick -> stays in SET_A_MIN, o_Alarm_Min_Inc strobes, timer restarts.
- In SET_T_MIN, 4 ticks -> o_Min_Blank toggles 1,0,1,0 starting from visible; o_Hr_Blank stays 0. Inc mid-sequence forces visible.
- Mode and Inc in the same cycle in SET_T_HR -> SET_T_MIN with no Inc strobe. Assert i_Reset mid-SET_A_HR -> next cycle all outputs at reset values.
